pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Reset and lock supervisor for the HDMI pixel-clock rPLL (27 MHz in, ~200 MHz out). It runs on the free-running 27 MHz board clock and drives the PLL's `RESET` input. It watches the PLL `lock` output and releases a system reset only after lock has been stable for a programmable time. Lock loss is handled by re-resetting the PLL, and it retries a bounded number of times before flagging a hard failure.

## Interface
Parameters:
- `PLLRST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset pulse (≥1).
- `LOCK_TIMEOUT`, 27000: cycles allowed in WAIT_LOCK before a retry (1 ms at 27 MHz).
- `STABLE_CYCLES`, 2700: consecutive cycles `lock` must stay high before release (100 µs).
- `MAX_RETRIES`, 3: lock timeouts tolerated before FAIL (≥1).
- `CNT_W`, 8: width of `loss_cnt`.

Ports:
- `clk`: in, 1. 27 MHz reference clock, never gated. One clock; reset is synchronous and active-high.
- `reset`: in, 1. Synchronous, active-high.
- `pll_lock`: in, 1. rPLL `LOCK`, asynchronous to `clk`.
- `pll_rst`: out, 1. To rPLL `RESET`, active-high.
- `sys_rst`: out, 1. Downstream reset, active-high. Consumers re-synchronize it into their own domain.
- `ready`: out, 1. High only in RUN.
- `fail`: out, 1. Sticky hard-failure flag.
- `state`: out, 3. 0 PLLRST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL.
- `loss_cnt`: out, CNT_W. Count of lock losses seen in RUN, saturating.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to give `lock_s`. The FSM sees only `lock_s`.
- PLLRST: `pll_rst`=1 and `sys_rst`=1. The timer runs `PLLRST_CYCLES` cycles, then the FSM goes to WAIT_LOCK with the timer cleared.
- WAIT_LOCK: `pll_rst`=0, `sys_rst`=1.
  - `lock_s`=1: go to STABLE with the timer cleared.
  - Timer reaches `LOCK_TIMEOUT`-1 with `lock_s`=0: increment `retry_cnt`.
  - If the new `retry_cnt` equals `MAX_RETRIES`, go to FAIL. Otherwise go to PLLRST.
- STABLE: `sys_rst`=1.
  - `lock_s`=0: go back to WAIT_LOCK with the timer cleared. This is not a retry.
  - `lock_s`=1 for `STABLE_CYCLES` consecutive cycles: go to RUN and clear `retry_cnt`.
- RUN: `sys_rst`=0, `ready`=1.
  - `lock_s`=0: go to PLLRST and increment `loss_cnt` once, saturating at 2^CNT_W−1.
- FAIL: `pll_rst`=1, `sys_rst`=1, `fail`=1. Only `reset` leaves this state.
- One shared timer of width `$clog2(max(PLLRST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1)` is used. It is cleared on every state change.
- `retry_cnt` is internal, `$clog2(MAX_RETRIES+1)` bits wide.

## Timing
- Reset values: state=PLLRST, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `loss_cnt`=0, timer=0, `retry_cnt`=0.
- All outputs are registered and are decoded from the next state, so each output changes in the same cycle `state` changes.
- After `reset` falls, `pll_rst` stays high for exactly `PLLRST_CYCLES` cycles.
- Lock detection latency is 2 cycles from a `pll_lock` edge to a `lock_s` edge.
- From `pll_lock` rising (clean) to `sys_rst` falling: 2 + `STABLE_CYCLES` + 1 cycles.
- From `lock_s` falling in RUN to `sys_rst`=1 and `ready`=0: 1 cycle.
- Reset asserted in any state, including FAIL or mid-count, returns to the reset values on the next edge.
- Tie-break at the timeout cycle: if `lock_s`=1 in the same cycle the timeout would fire, lock wins and the FSM goes to STABLE.

## Configuration
- `PLL_SUP_RETRY_EN` defined: timeout, retry and FAIL behave as described above.
- `PLL_SUP_RETRY_EN` undefined:
  - WAIT_LOCK waits for lock indefinitely and has no timeout.
  - `retry_cnt` and the FAIL state are not built; `fail` is tied to 0.
  - State code 4 is never produced.

## Test plan
Bench parameters: PLLRST=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2, CNT_W=2, macro defined.
- Reset release with `pll_lock` rising 10 cycles later: `pll_rst` is high for 4 cycles after reset. `sys_rst` falls and `ready` rises 11 cycles (2+8+1) after the `pll_lock` edge.
- `pll_lock` glitches low for 3 cycles during STABLE: state returns to 1, then re-enters STABLE. `sys_rst` falls only after 8 uninterrupted locked cycles. `loss_cnt` stays 0.
- `pll_lock` never asserts: two 4-cycle `pll_rst` pulses occur, separated by 20-cycle waits. After the second timeout, state=4 and `fail`=1 stick. `reset` clears them.
- `pll_lock` is dropped 5 times while in RUN: `ready` falls 1 cycle after each `lock_s` fall. `loss_cnt` reads 1, 2, 3, 3, 3 (saturated).
- `pll_lock` and the timeout coincide in the timeout cycle: the next state is STABLE and `retry_cnt` is unchanged.
- Macro undefined with `pll_lock` held 0 for 200 cycles: state stays 1, `pll_rst` stays 0, `fail`=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: rPLL reset/lock supervisor; define PLL_SUP_RETRY_EN to build lock timeout, retries and FAIL
module pll_lock_supervisor #(
  parameter int PLLRST_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 2700,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             fail,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] loss_cnt
);
  localparam int T_AB  = PLLRST_CYCLES > LOCK_TIMEOUT ? PLLRST_CYCLES : LOCK_TIMEOUT;
  localparam int T_MAX = T_AB > STABLE_CYCLES ? T_AB : STABLE_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam logic [2:0] S_PLLRST = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;
  logic          sync1, lock_s;
  logic [TW-1:0] timer;
  logic [2:0]    nxt;
  logic          timeout, give_up;
  // two-flop synchronizer for the asynchronous PLL lock; free-running so it is primed when reset drops
  always_ff @(posedge clk) begin
    sync1  <= pll_lock;
    lock_s <= sync1;
  end
  // next state; lock beats a coinciding timeout because it is tested first
  always_comb begin
    nxt = state;
    case (state)
      S_PLLRST: nxt = timer == TW'(PLLRST_CYCLES - 1) ? S_WAIT : S_PLLRST;
      S_WAIT:   nxt = lock_s ? S_STABLE : timeout ? (give_up ? S_FAIL : S_PLLRST) : S_WAIT;
      S_STABLE: nxt = !lock_s ? S_WAIT : timer == TW'(STABLE_CYCLES - 1) ? S_RUN : S_STABLE;
      S_RUN:    nxt = lock_s ? S_RUN : S_PLLRST;
      default:  nxt = state == S_FAIL ? S_FAIL : S_PLLRST;
    endcase
  end
  // state, shared timer and outputs decoded from the next state so they switch together with state
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_PLLRST;
      timer    <= '0;
      pll_rst  <= 1'b1;
      sys_rst  <= 1'b1;
      ready    <= 1'b0;
      loss_cnt <= '0;
    end else begin
      state    <= nxt;
      timer    <= nxt != state ? '0 : timer + 1'b1;
      pll_rst  <= nxt == S_PLLRST || nxt == S_FAIL;
      sys_rst  <= nxt != S_RUN;
      ready    <= nxt == S_RUN;
      loss_cnt <= loss_cnt + CNT_W'(state == S_RUN && !lock_s && loss_cnt != '1);
    end
  end
`ifdef PLL_SUP_RETRY_EN
  localparam int RW = $clog2(MAX_RETRIES + 1);
  logic [RW-1:0] retry_cnt;
  assign timeout = state == S_WAIT && !lock_s && timer == TW'(LOCK_TIMEOUT - 1);
  assign give_up = retry_cnt == RW'(MAX_RETRIES - 1);
  // timeouts since the last successful lock; the one that reaches the limit parks the FSM in FAIL
  always_ff @(posedge clk) begin
    if (reset) begin
      retry_cnt <= '0;
      fail      <= 1'b0;
    end else begin
      retry_cnt <= nxt == S_RUN ? '0 : retry_cnt + RW'(timeout);
      fail      <= nxt == S_FAIL;
    end
  end
`else
  assign timeout = 1'b0;
  assign give_up = 1'b0;
  assign fail    = 1'b0;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scenario tasks plus random lock traffic against a behavioural supervisor model
module tb_pll_lock_supervisor;
  localparam int P_RST = 4, TO = 20, ST = 8, MR = 2, CW = 2;
  localparam int LOSS_MAX = (1 << CW) - 1;
`ifdef PLL_SUP_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, pll_lock = 1'b0;
  logic pll_rst, sys_rst, ready, fail;
  logic [2:0] state;
  logic [CW-1:0] loss_cnt;
  int vectors = 0, miscompares = 0;
  int m_st = 0, m_dw = 0, m_retry = 0, m_loss = 0;
  bit m_s1 = 1'b0, m_ls = 1'b0;
  pll_lock_supervisor #(.PLLRST_CYCLES(P_RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST),
                        .MAX_RETRIES(MR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pll_lock(pll_lock), .pll_rst(pll_rst), .sys_rst(sys_rst),
    .ready(ready), .fail(fail), .state(state), .loss_cnt(loss_cnt));
  always #5 clk = ~clk;
  function automatic logic [8:0] dut_vec();
    return {state, pll_rst, sys_rst, ready, fail, loss_cnt};
  endfunction
  function automatic logic [8:0] mdl_vec();
    return {3'(m_st), m_st == 0 || m_st == 4, m_st != 3, m_st == 3, m_st == 4, 2'(m_loss)};
  endfunction
  task automatic model_edge(input bit r, input bit lk);
    int nst;
    nst = m_st;
    if (r) begin
      m_st = 0; m_dw = 0; m_retry = 0; m_loss = 0;
    end else begin
      if (m_st == 0 && m_dw == P_RST - 1) nst = 1;
      else if (m_st == 1 && m_ls) nst = 2;
      else if (m_st == 1 && RETRY && m_dw == TO - 1) begin
        m_retry++;
        nst = m_retry == MR ? 4 : 0;
      end
      else if (m_st == 2 && !m_ls) nst = 1;
      else if (m_st == 2 && m_dw == ST - 1) begin nst = 3; m_retry = 0; end
      else if (m_st == 3 && !m_ls) begin
        nst = 0;
        m_loss = m_loss == LOSS_MAX ? LOSS_MAX : m_loss + 1;
      end
      m_dw = nst == m_st ? m_dw + 1 : 0;
      m_st = nst;
    end
    m_ls = m_s1;
    m_s1 = lk;
  endtask
  task automatic step(input bit r, input bit lk);
    reset = r;
    pll_lock = lk;
    @(posedge clk);
    model_edge(r, lk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1, 1'($urandom_range(0, 1)));
    step(1, 0);
    step(1, 0);
    vectors++;
    if (dut_vec() !== 9'b000_1_1_0_0_00) begin
      miscompares++;
      $display("FAIL reset_values got %b expected %b", dut_vec(), 9'b000_1_1_0_0_00);
    end
  endtask
  task automatic test_release();
    int fall_at, n;
    fall_at = 0;
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL release_model cyc %0d got %b expected %b", i, dut_vec(), mdl_vec());
      end
      if (!pll_rst && fall_at == 0) fall_at = i;
    end
    vectors++;
    if (fall_at != P_RST) begin
      miscompares++;
      $display("FAIL pll_rst_width got %0d expected %0d", fall_at, P_RST);
    end
    n = 0;
    while (sys_rst && n < 40) begin
      step(0, 1);
      n++;
    end
    vectors++;
    if (n != ST + 3 || sys_rst !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_to_release got %0d cycles sys_rst=%b ready=%b expected %0d 0 1", n, sys_rst, ready, ST + 3);
    end
  endtask
  task automatic test_glitch();
    int n;
    bit seen_wait;
    seen_wait = 0;
    for (int i = 0; i < 3; i++) step(1, 0);
    n = 0;
    while (state !== 3'd1 && n < 20) begin step(0, 0); n++; end
    n = 0;
    while (state !== 3'd2 && n < 20) begin step(0, 1); n++; end
    step(0, 1);
    step(0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      if (state === 3'd1) seen_wait = 1;
    end
    vectors++;
    if (!seen_wait || dut_vec() !== mdl_vec()) begin
      miscompares++;
      $display("FAIL glitch_back_to_wait seen=%0d got %b expected %b", seen_wait, dut_vec(), mdl_vec());
    end
    n = 0;
    while (sys_rst && n < 40) begin step(0, 1); n++; end
    vectors++;
    if (n != ST + 3 || loss_cnt !== 2'd0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_release got %0d cycles loss=%0d ready=%b expected %0d 0 1", n, loss_cnt, ready, ST + 3);
    end
  endtask
  task automatic test_no_lock();
    int waits, falls, run, last_run, fails;
    bit prev;
    waits = 0; falls = 0; run = 0; last_run = 0; fails = 0;
    for (int i = 0; i < 3; i++) step(1, 0);
    prev = pll_rst;
    for (int i = 1; i <= (RETRY ? 100 : 200); i++) begin
      step(0, 0);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL no_lock_model cyc %0d got %b expected %b", i, dut_vec(), mdl_vec());
      end
      if (state === 3'd1) waits++;
      if (fail === 1'b1) fails++;
      if (pll_rst) run++;
      if (prev && !pll_rst) begin falls++; last_run = run; end
      if (!pll_rst) run = 0;
      prev = pll_rst;
    end
    vectors++;
    if (RETRY) begin
      if (waits != 2 * TO || falls != 2 || last_run != P_RST || state !== 3'd4 || fail !== 1'b1) begin
        miscompares++;
        $display("FAIL no_lock_retry waits=%0d falls=%0d pulse=%0d state=%0d fail=%b expected %0d 2 %0d 4 1",
                 waits, falls, last_run, state, fail, 2 * TO, P_RST);
      end
    end else if (waits != 200 - P_RST + 1 || falls != 1 || fails != 0 || state !== 3'd1 || pll_rst !== 1'b0) begin
      miscompares++;
      $display("FAIL no_lock_wait waits=%0d falls=%0d fails=%0d state=%0d pll_rst=%b expected %0d 1 0 1 0",
               waits, falls, fails, state, pll_rst, 200 - P_RST + 1);
    end
    step(1, 0);
    vectors++;
    if (state !== 3'd0 || fail !== 1'b0 || pll_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_from_fail state=%0d fail=%b pll_rst=%b expected 0 0 1", state, fail, pll_rst);
    end
  endtask
  task automatic test_run_drops();
    int n;
    bit r1, r2;
    int exp_loss[5] = '{1, 2, 3, 3, 3};
    for (int i = 0; i < 3; i++) step(1, 0);
    n = 0;
    while (!ready && n < 60) begin step(0, 1); n++; end
    for (int k = 0; k < 5; k++) begin
      step(0, 0);
      step(0, 0);
      r1 = ready;
      step(0, 1);
      r2 = ready;
      vectors++;
      if (r1 !== 1'b1 || r2 !== 1'b0 || sys_rst !== 1'b1 || int'(loss_cnt) != exp_loss[k]) begin
        miscompares++;
        $display("FAIL run_drop %0d ready %b->%b sys_rst=%b loss=%0d expected 1->0 1 %0d",
                 k, r1, r2, sys_rst, loss_cnt, exp_loss[k]);
      end
      n = 0;
      while (!ready && n < 60) begin step(0, 1); n++; end
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL run_recover %0d got %b expected %b", k, dut_vec(), mdl_vec());
      end
    end
  endtask
  task automatic test_tie();
    int n;
    logic [2:0] s23;
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 1; i <= 21; i++) step(0, 0);
    step(0, 1);
    step(0, 1);
    s23 = state;
    step(0, 1);
    vectors++;
    if (s23 !== 3'd1 || state !== 3'd2) begin
      miscompares++;
      $display("FAIL tie_lock_wins states %0d,%0d expected 1,2", s23, state);
    end
    n = 0;
    while ((state === 3'd1 || state === 3'd2) && n < 60) begin step(0, 0); n++; end
    vectors++;
    if (RETRY ? (state !== 3'd0 || n != 2 + TO + 1) : state !== 3'd1) begin
      miscompares++;
      $display("FAIL tie_retry_unchanged state=%0d after %0d cycles expected %0d", state, n, RETRY ? 0 : 1);
    end
  endtask
  task automatic test_random();
    int left;
    bit lvl;
    left = 0; lvl = 0;
    for (int i = 0; i < 3; i++) step(1, 0);
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        lvl = ~lvl;
        left = lvl ? $urandom_range(1, 40) : $urandom_range(1, 30);
      end
      left--;
      step($urandom_range(0, 149) == 0, lvl);
      vectors++;
      if (dut_vec() !== mdl_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
  endtask
  initial begin
    test_reset();
    test_release();
    test_glitch();
    test_no_lock();
    test_run_drops();
    test_tie();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
